sb_tx_serializer: RTL and testbench
===================================

Name: sb_tx_serializer

Overview:
- Downstream stage of the sideband transactions generator.
- Consumes its 10-bit framed symbols (trans), trans_state, crc_en and sbtx_sel, and drives the single-wire SBTX line one bit per sb_clk, LSB first.
- Computes the CRC-16 over payload bytes bit-serially and substitutes the two CRC bytes, framed with start/stop bits, when sbtx_sel is asserted.
- Sits between the transactions generator and the SBTX pad driver.

Parameters:
- SYM_BITS, 10, bits per framed symbol (start + 8 data + stop).
- CRC_POLY, 16'h8005, CRC-16 generator polynomial (x^16+x^15+x^2+1).
- CRC_SEED, 16'hFFFF, CRC register value at the start of each transaction.

Ports:
- sb_clk  in  1  sideband clock.
- rst  in  1  asynchronous, active-low reset.
- trans  in  10  framed symbol: bit0 = start (0), bits[8:1] = data byte LSB first, bit9 = stop (1); all-ones = idle.
- trans_state  in  2  0 = DISCONNECTED, 1 = IDLE, 2 = START.
- crc_en  in  1  current symbol's data byte is CRC-covered.
- sbtx_sel  in  1  current symbol slot carries CRC instead of trans.
- sbtx  out  1  serial sideband line.
- sym_done  out  1  one-cycle pulse on the last bit (stop) of every symbol sent in START.
- crc_out  out  16  current CRC register value (debug and verification).

Behaviour:
- Reset (rst = 0): sbtx = 0, sym_done = 0, crc_out = CRC_SEED, bit_cnt = 0, shifter = 0, crc_byte_idx = 0.
- Modes are set by trans_state, sampled each edge.
  - DISCONNECTED: sbtx <= 0; bit_cnt, crc and crc_byte_idx held at reset values.
  - IDLE: sbtx <= 1; bit_cnt <= 0; crc <= CRC_SEED; crc_byte_idx <= 0.
  - START: bit_cnt counts 0..SYM_BITS-1 and wraps to 0. The first START cycle has bit_cnt = 0, so counting aligns with the generator, which holds each symbol for exactly 10 cycles.
- Load, on an edge in START with bit_cnt == 0:
  - If sbtx_sel = 0: sbtx <= trans[0]; shifter <= trans >> 1; cov <= crc_en.
  - If sbtx_sel = 1: build the symbol {1'b1, byte, 1'b0}, where byte = crc[7:0] if crc_byte_idx = 0, else crc[15:8]. Then crc_byte_idx toggles and cov <= 0.
- Shift, on edges with bit_cnt 1..9: sbtx <= shifter[0]; shifter >>= 1.
- Latency: sbtx is registered, so each bit appears one cycle after the cycle its symbol's load occurs in. A symbol occupies sbtx for exactly 10 consecutive cycles.
- CRC update:
  - When cov = 1 and bit_cnt is 1..8, each data bit d = shifter[0] updates the register: fb = d ^ crc[15]; crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 0).
  - The start bit, stop bit, DLE/ETX/LSE delimiters (cov = 0) and the CRC symbols do not update the CRC.
  - The CRC is frozen once sbtx_sel has been sampled high.
- sym_done = 1 on the edge where bit_cnt == 9 in START, otherwise 0.
- Boundary conditions:
  - trans_state leaving START mid-symbol: the symbol is abandoned; the new mode takes effect on the next edge.
  - sbtx_sel high for more than 2 symbols: crc_byte_idx wraps and alternates low/high bytes. No error is flagged.
  - trans changing when bit_cnt != 0: ignored; only the load-edge value matters.
  - Reset asserted mid-transaction: all state is cleared immediately and sbtx = 0.
  - An all-ones trans in START (after ETX, before trans_state returns to IDLE): transmitted as a normal idle symbol with sbtx = 1.

Decomposition:
- Shared package sb_pkg:
  - trans_state encodings DISCONNECTED_S/IDLE_S/START.
  - Symbol constants DLE = 8'hFE, STX_CMD = 8'h05, STX_RSP = 8'h04, ETX = 8'h40, LSE = 8'h80.
  - SYM_BITS, CRC_POLY, CRC_SEED.
- Sub-module sb_crc16_serial:
  - Inputs: clk, rst, clr (load seed), en, d.
  - Output: crc[15:0].
  - Instantiated once.

Test Plan:
- Reset check: rst low for 3 cycles, then high with trans_state = 0 -> sbtx = 0, sym_done = 0, crc_out = 16'hFFFF.
- Idle: trans_state = 1, trans = 10'h3FF for 20 cycles -> sbtx = 1 every cycle and no sym_done pulse.
- DLE symbol: trans_state 1->2 with trans = 10'h3FC -> sbtx = 0,0,1,1,1,1,1,1,1,1 on the 10 cycles after load, and sym_done pulses once on the 10th cycle of the symbol.
- CRC seed emission: in START, sbtx_sel = 1 for two symbols with no prior crc_en byte -> each symbol serializes as 0, eight 1s, 1; crc_out stays 16'hFFFF throughout.
- AT read response: drive generator-style sequence DLE, STX 8'h04, address 8'd78, length 8'h03, data 8'hA5/8'h5A/8'h3C, CRC, CRC, DLE, ETX with crc_en on for STX..data -> the CRC bytes on sbtx match a bit-serial 0x8005 / seed 0xFFFF model over 04,4E,03,A5,5A,3C, and the delimiters are unchanged.
- Abort: rst pulsed low at bit_cnt = 5 of a data symbol -> sbtx = 0 in the same cycle, and after release the next START load resumes at bit_cnt = 0 with crc_out = 16'hFFFF.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared sideband definitions: trans_state encodings, framing symbols and CRC-16 constants.
package sb_pkg;

    localparam int          SYM_BITS = 10;
    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    localparam logic [7:0] DLE     = 8'hFE;
    localparam logic [7:0] STX_CMD = 8'h05;
    localparam logic [7:0] STX_RSP = 8'h04;
    localparam logic [7:0] ETX     = 8'h40;
    localparam logic [7:0] LSE     = 8'h80;

    typedef enum logic [1:0] {
        DISCONNECTED_S = 2'd0,
        IDLE_S         = 2'd1,
        START          = 2'd2
    } trans_state_e;

    // Wraps a byte with a low start bit and a high stop bit.
    function automatic logic [SYM_BITS-1:0] frame_byte(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

endpackage

// File: rtl/sb_crc16_serial.sv
// Bit-serial CRC-16 register, MSB-out feedback; clr reloads the seed and wins over en.
module sb_crc16_serial #(
    parameter logic [15:0] POLY = sb_pkg::CRC_POLY,
    parameter logic [15:0] SEED = sb_pkg::CRC_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        d,
    output logic [15:0] crc
);

    logic fb;

    assign fb = d ^ crc[15];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= SEED;
        end else if (clr) begin
            crc <= SEED;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sb_tx_serializer.sv
// Serializes framed sideband symbols onto SBTX, LSB first, substituting CRC bytes when sbtx_sel is set.
module sb_tx_serializer #(
    parameter int          SYM_BITS = sb_pkg::SYM_BITS,
    parameter logic [15:0] CRC_POLY = sb_pkg::CRC_POLY,
    parameter logic [15:0] CRC_SEED = sb_pkg::CRC_SEED
) (
    input  logic                sb_clk,
    input  logic                rst,
    input  logic [SYM_BITS-1:0] trans,
    input  logic [1:0]          trans_state,
    input  logic                crc_en,
    input  logic                sbtx_sel,
    output logic                sbtx,
    output logic                sym_done,
    output logic [15:0]         crc_out
);
    import sb_pkg::*;

    localparam int               CNT_W     = $clog2(SYM_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SYM_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(SYM_BITS - 2);

    logic [CNT_W-1:0]    bit_cnt;
    logic [SYM_BITS-1:0] shifter;
    logic [SYM_BITS-1:0] load_sym;
    logic [7:0]          crc_byte;
    logic                cov;
    logic                crc_byte_idx;
    logic                crc_frozen;
    logic                in_start;
    logic                crc_upd;

    assign in_start = (trans_state == START);
    assign crc_byte = crc_byte_idx ? crc_out[15:8] : crc_out[7:0];
    assign load_sym = sbtx_sel ? frame_byte(crc_byte) : trans;

    // Only the eight data bits of a covered symbol feed the CRC; shifter[0] holds the bit being sent.
    assign crc_upd = in_start && cov && (bit_cnt != '0) && (bit_cnt <= LAST_DATA);

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            sbtx         <= 1'b0;
            sym_done     <= 1'b0;
            bit_cnt      <= '0;
            shifter      <= '0;
            cov          <= 1'b0;
            crc_byte_idx <= 1'b0;
            crc_frozen   <= 1'b0;
        end else begin
            case (trans_state)
                START: begin
                    bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    sym_done <= (bit_cnt == LAST_BIT);
                    if (bit_cnt == '0) begin
                        sbtx    <= load_sym[0];
                        shifter <= load_sym >> 1;
                        if (sbtx_sel) begin
                            // Once CRC emission starts the register must not move again this transaction.
                            crc_byte_idx <= ~crc_byte_idx;
                            crc_frozen   <= 1'b1;
                            cov          <= 1'b0;
                        end else begin
                            cov <= crc_en && !crc_frozen;
                        end
                    end else begin
                        sbtx    <= shifter[0];
                        shifter <= shifter >> 1;
                    end
                end
                IDLE_S: begin
                    sbtx         <= 1'b1;
                    sym_done     <= 1'b0;
                    bit_cnt      <= '0;
                    shifter      <= '0;
                    cov          <= 1'b0;
                    crc_byte_idx <= 1'b0;
                    crc_frozen   <= 1'b0;
                end
                default: begin
                    sbtx         <= 1'b0;
                    sym_done     <= 1'b0;
                    bit_cnt      <= '0;
                    shifter      <= '0;
                    cov          <= 1'b0;
                    crc_byte_idx <= 1'b0;
                    crc_frozen   <= 1'b0;
                end
            endcase
        end
    end

    sb_crc16_serial #(
        .POLY(CRC_POLY),
        .SEED(CRC_SEED)
    ) u_crc (
        .clk(sb_clk),
        .rst(rst),
        .clr(!in_start),
        .en (crc_upd),
        .d  (shifter[0]),
        .crc(crc_out)
    );

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Scoreboard bench: the driver pushes per-cycle expectations from a byte-level model, a negedge monitor compares.
module tb_sb_tx_serializer;
    import sb_pkg::*;

    logic        sb_clk = 1'b0;
    logic        rst;
    logic [9:0]  trans;
    logic [1:0]  trans_state;
    logic        crc_en;
    logic        sbtx_sel;
    logic        sbtx;
    logic        sym_done;
    logic [15:0] crc_out;

    always #5 sb_clk = ~sb_clk;

    sb_tx_serializer dut (
        .sb_clk     (sb_clk),
        .rst        (rst),
        .trans      (trans),
        .trans_state(trans_state),
        .crc_en     (crc_en),
        .sbtx_sel   (sbtx_sel),
        .sbtx       (sbtx),
        .sym_done   (sym_done),
        .crc_out    (crc_out)
    );

    typedef struct {
        bit          line;
        bit          done;
        bit          chk_crc;
        logic [15:0] crc;
        int          sym;
        int          bitn;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          sym_id = 0;
    logic [15:0] m_crc  = 16'hFFFF;
    bit          m_idx  = 1'b0;
    bit          m_frozen = 1'b0;
    logic [7:0]  body[$];

    // Reference CRC: each byte goes in LSB first against x^16+x^15+x^2+1.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (b[i] ^ r[15]) r = (r << 1) ^ 16'h8005;
            else              r = r << 1;
        end
        return r;
    endfunction

    function automatic logic [9:0] fr(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic push(input bit l, input bit d, input bit chk, input logic [15:0] c, input int bn);
        exp_t e;
        e.line = l; e.done = d; e.chk_crc = chk; e.crc = c; e.sym = sym_id; e.bitn = bn;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge sb_clk);
        #1;
    endtask

    task automatic model_clear();
        m_crc = 16'hFFFF; m_idx = 1'b0; m_frozen = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            trans_state = 2'd1; trans = 10'h3FF;
            crc_en = 1'($urandom); sbtx_sel = 1'($urandom);
            model_clear();
            push(1'b1, 1'b0, 1'b1, 16'hFFFF, -1);
            tick();
        end
    endtask

    task automatic disc(input int n);
        for (int i = 0; i < n; i++) begin
            trans_state = 2'd0; trans = 10'($urandom);
            crc_en = 1'($urandom); sbtx_sel = 1'($urandom);
            model_clear();
            push(1'b0, 1'b0, 1'b1, 16'hFFFF, -1);
            tick();
        end
    endtask

    // One symbol slot in START; nbits < 10 abandons it early. Non-load cycles get random inputs.
    task automatic send(input logic [9:0] t, input bit ce, input bit sel, input int nbits);
        logic [9:0]  bits;
        logic [15:0] c0, c1;
        bit          cov;
        c0 = m_crc;
        if (sel) begin
            bits = fr(m_idx ? m_crc[15:8] : m_crc[7:0]);
            m_idx = ~m_idx; m_frozen = 1'b1; cov = 1'b0;
        end else begin
            bits = t; cov = ce && !m_frozen;
        end
        c1 = cov ? crc_byte(m_crc, bits[8:1]) : m_crc;
        sym_id++;
        for (int j = 0; j < nbits; j++) begin
            trans_state = 2'd2;
            if (j == 0) begin
                trans = t; crc_en = ce; sbtx_sel = sel;
            end else begin
                trans = 10'($urandom); crc_en = 1'($urandom); sbtx_sel = 1'($urandom);
            end
            push(bits[j], j == 9, (j == 0) || (j == 9), (j == 9) ? c1 : c0, j);
            tick();
        end
        m_crc = c1;
    endtask

    task automatic send_frame(input logic [7:0] stx, input bit tail_ce, input bit idle_sym);
        send(fr(DLE), 1'b0, 1'b0, 10);
        send(fr(stx), 1'b1, 1'b0, 10);
        foreach (body[i]) send(fr(body[i]), 1'b1, 1'b0, 10);
        send(10'($urandom), 1'b0, 1'b1, 10);
        send(10'($urandom), 1'b0, 1'b1, 10);
        send(fr(DLE), tail_ce, 1'b0, 10);
        send(fr(ETX), tail_ce, 1'b0, 10);
        if (idle_sym) send(10'h3FF, 1'b0, 1'b0, 10);
        idle(2);
    endtask

    always @(negedge sb_clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (sbtx !== e.line) begin
                errors++;
                $display("FAIL sbtx sym %0d bit %0d: got %b want %b", e.sym, e.bitn, sbtx, e.line);
            end
            checks++;
            if (sym_done !== e.done) begin
                errors++;
                $display("FAIL sym_done sym %0d bit %0d: got %b want %b", e.sym, e.bitn, sym_done, e.done);
            end
            if (e.chk_crc) begin
                checks++;
                if (crc_out !== e.crc) begin
                    errors++;
                    $display("FAIL crc_out sym %0d bit %0d: got %h want %h", e.sym, e.bitn, crc_out, e.crc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; trans_state = 2'd0; trans = 10'h3FF; crc_en = 1'b0; sbtx_sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 1'b0, 1'b1, 16'hFFFF, -1);
            tick();
        end
        rst = 1'b1;
        disc(3);
        idle(20);

        // DLE after idle, then seed CRC bytes with a wrap to the low byte again.
        send(10'h3FC, 1'b0, 1'b0, 10);
        send(10'h000, 1'b0, 1'b1, 10);
        send(10'h000, 1'b0, 1'b1, 10);
        send(10'h000, 1'b0, 1'b1, 10);
        send(10'h3FF, 1'b0, 1'b0, 10);
        idle(3);

        // AT read response.
        body = '{8'd78, 8'h03, 8'hA5, 8'h5A, 8'h3C};
        send_frame(STX_RSP, 1'b0, 1'b1);

        // Leaving START mid-symbol, to IDLE and to DISCONNECTED.
        send(fr(DLE), 1'b0, 1'b0, 10);
        send(fr(STX_CMD), 1'b1, 1'b0, 4);
        idle(2);
        send(fr(8'hA5), 1'b1, 1'b0, 10);
        send(fr(8'h5A), 1'b1, 1'b0, 6);
        disc(2);
        idle(1);

        // Reset asserted while bit_cnt is 5 of a covered data symbol.
        send(fr(STX_CMD), 1'b1, 1'b0, 10);
        send(fr(8'hC3), 1'b1, 1'b0, 4);
        push(1'b0, 1'b0, 1'b1, 16'hFFFF, -1);
        tick();
        rst = 1'b0;
        model_clear();
        trans_state = 2'd2;
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 1'b0, 1'b1, 16'hFFFF, -1);
            tick();
        end
        rst = 1'b1;
        send(fr(LSE), 1'b1, 1'b0, 10);
        send(10'h0, 1'b0, 1'b1, 10);
        send(10'h0, 1'b0, 1'b1, 10);
        idle(2);

        // Random frames.
        for (int f = 0; f < 30; f++) begin
            int len;
            len = int'($urandom_range(1, 4));
            body = {};
            body.push_back(8'($urandom));
            body.push_back(8'(len));
            for (int k = 0; k < len; k++) body.push_back(8'($urandom));
            send_frame($urandom_range(0, 1) ? STX_CMD : STX_RSP, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                send(fr(8'($urandom)), 1'b1, 1'b0, int'($urandom_range(1, 9)));
                idle(1);
            end
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge sb_clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
